// File: rtl/muller_c_proj_pkg.sv
// Shared constants and C-element next-state helpers for the muller_c_proj core.
// Bit positions on the pad buses are named here so every file agrees on them.
package muller_c_proj_pkg;

    localparam int A    = 0;
    localparam int B    = 1;
    localparam int C    = 2;
    localparam int MODE = 3;
    localparam int CLR  = 4;
    localparam int INV  = 5;

    localparam int Y      = 0;
    localparam int YN     = 1;
    localparam int TP     = 2;
    localparam int HOLD   = 3;
    localparam int CNT_LO = 4;

    localparam logic [5:0] OEB_ALL_OUT = 6'b000000;

    // In 2-input mode c must not influence either condition.
    function automatic logic sel_all1(input logic a, input logic b,
                                      input logic c, input logic mode);
        return a & b & (c | ~mode);
    endfunction

    function automatic logic sel_all0(input logic a, input logic b,
                                      input logic c, input logic mode);
        return ~a & ~b & (~c | ~mode);
    endfunction

    function automatic logic c_next(input logic a, input logic b, input logic c,
                                    input logic mode, input logic clr,
                                    input logic q);
        logic nxt;
        if (clr)                           nxt = 1'b0;
        else if (sel_all1(a, b, c, mode))  nxt = 1'b1;
        else if (sel_all0(a, b, c, mode))  nxt = 1'b0;
        else                               nxt = q;
        return nxt;
    endfunction

endpackage

// File: rtl/muller_c_element.sv
// Synchronous Muller C-element with 2/3-input selection and a synchronous clear.
module muller_c_element
    import muller_c_proj_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic a,
    input  logic b,
    input  logic c,
    input  logic mode,
    input  logic clr,
    output logic q
);

    logic q_d;
    logic q_q;

    always_comb begin
        q_d = c_next(a, b, c, mode, clr, q_q);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) q_q <= 1'b0;
        else        q_q <= q_d;
    end

    assign q = q_q;

endmodule

// File: rtl/muller_c_proj_core.sv
// Pad-facing wrapper: registers io_in, runs the C-element and reports
// polarity-adjusted state, a transition pulse, hold status and a transition count.
module muller_c_proj_core
    import muller_c_proj_pkg::*;
#(
    parameter int CNT_W = 2,
    parameter int IO_W  = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [IO_W-1:0] io_in,
    output logic [IO_W-1:0] io_out,
    output logic [IO_W-1:0] io_oeb
);

    logic [IO_W-1:0]  in_d,     in_q;
    logic             tpulse_d, tpulse_q;
    logic [CNT_W-1:0] tcnt_d,   tcnt_q;
    logic             q;
    logic             q_change;
    logic             y;
    logic             hold;

    muller_c_element u_celem (
        .clk  (clk),
        .rst_n(rst_n),
        .a    (in_q[A]),
        .b    (in_q[B]),
        .c    (in_q[C]),
        .mode (in_q[MODE]),
        .clr  (in_q[CLR]),
        .q    (q)
    );

    // Predict the element's next value so the pulse and count line up with its update edge.
    always_comb begin
        q_change = c_next(in_q[A], in_q[B], in_q[C], in_q[MODE], in_q[CLR], q) != q;
        in_d     = io_in;
        tpulse_d = q_change;
        tcnt_d   = tcnt_q + CNT_W'(q_change);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            in_q     <= '0;
            tpulse_q <= 1'b0;
            tcnt_q   <= '0;
        end else begin
            in_q     <= in_d;
            tpulse_q <= tpulse_d;
            tcnt_q   <= tcnt_d;
        end
    end

    always_comb begin
        y    = q ^ in_q[INV];
        hold = ~in_q[CLR]
             & ~sel_all1(in_q[A], in_q[B], in_q[C], in_q[MODE])
             & ~sel_all0(in_q[A], in_q[B], in_q[C], in_q[MODE]);
        io_out                     = '0;
        io_out[Y]                  = y;
        io_out[YN]                 = ~y;
        io_out[TP]                 = tpulse_q;
        io_out[HOLD]               = hold;
        io_out[CNT_LO +: CNT_W]    = tcnt_q;
    end

    assign io_oeb = OEB_ALL_OUT;

endmodule

// File: tb/tb_muller_c_proj_core.sv
// Bench for muller_c_proj_core: directed literal checks plus randomized traffic
// compared every cycle against a counting-based behavioural model.
module tb_muller_c_proj_core;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] io_in;
    logic [5:0] io_out;
    logic [5:0] io_oeb;

    int checks   = 0;
    int failures = 0;
    bit model_ok = 1'b0;

    // Model state: what the pads looked like last edge, plus state/pulse/count.
    logic [5:0] m_in;
    int         m_q, m_tp, m_cnt;

    muller_c_proj_core #(.CNT_W(2), .IO_W(6)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io_in (io_in),
        .io_out(io_out),
        .io_oeb(io_oeb)
    );

    always #5 clk = ~clk;

    function automatic int n_ones(input logic [5:0] v);
        int n = v[0] + v[1];
        if (v[3]) n += v[2];
        return n;
    endfunction

    function automatic int n_sel(input logic [5:0] v);
        return v[3] ? 3 : 2;
    endfunction

    function automatic logic [5:0] model_out();
        int y, hold;
        y    = m_q ^ int'(m_in[5]);
        hold = (!m_in[4] && n_ones(m_in) != 0 && n_ones(m_in) != n_sel(m_in)) ? 1 : 0;
        return {2'(m_cnt), 1'(hold), 1'(m_tp), 1'(1 - y), 1'(y)};
    endfunction

    always @(posedge clk) begin
        int nq;
        if (!rst_n) begin
            m_in = '0; m_q = 0; m_tp = 0; m_cnt = 0;
            model_ok = 1'b1;
        end else begin
            if (m_in[4])                            nq = 0;
            else if (n_ones(m_in) == n_sel(m_in))   nq = 1;
            else if (n_ones(m_in) == 0)             nq = 0;
            else                                    nq = m_q;
            m_tp  = (nq != m_q) ? 1 : 0;
            m_cnt = (m_cnt + m_tp) % 4;
            m_q   = nq;
            m_in  = io_in;
        end
    end

    always @(negedge clk) begin
        if (model_ok) begin
            checks++;
            if (io_out !== model_out()) begin
                failures++;
                $display("FAIL model_io_out t=%0t got=%b want=%b", $time, io_out, model_out());
            end
            checks++;
            if (io_oeb !== 6'b000000) begin
                failures++;
                $display("FAIL io_oeb t=%0t got=%b want=000000", $time, io_oeb);
            end
        end
    end

    task automatic check(input string name, input logic [5:0] got, input logic [5:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%b want=%b", name, got, want);
        end
    endtask

    task automatic cyc(input logic [5:0] v);
        io_in = v;
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        repeat (n) cyc(6'b000000);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        io_in = '0;
        do_reset(2);
        check("reset_out", io_out, 6'b000010);
        check("reset_oeb", io_oeb, 6'b000000);

        repeat (3) cyc(6'b110000);
        check("clr_inv_hold3", io_out, 6'b000001);

        do_reset(1);
        cyc(6'b000011);
        check("set_lat1", io_out, 6'b000010);
        cyc(6'b000011);
        check("set_lat2", io_out, 6'b010101);
        cyc(6'b000011);
        check("tpulse_drop", io_out, 6'b010001);

        for (int i = 0; i < 4; i++) begin
            cyc(6'b000001);
            check("disagree_hold", io_out, 6'b011001);
        end
        cyc(6'b000000);
        check("clear_lat1", io_out, 6'b010001);
        cyc(6'b000000);
        check("clear_lat2", io_out, 6'b100110);

        cyc(6'b001011);
        check("mode3_hold", io_out, 6'b101010);
        cyc(6'b001011);
        check("mode3_hold2", io_out, 6'b101010);
        cyc(6'b001111);
        check("mode3_lat1", io_out, 6'b100010);
        cyc(6'b001111);
        check("mode3_set", io_out, 6'b110101);

        cyc(6'b010011);
        check("clr_lat1", io_out, 6'b110001);
        cyc(6'b010011);
        check("clr_wins", io_out, 6'b000110);

        do_reset(1);
        for (int i = 0; i < 4; i++) begin
            logic [5:0] v;
            v = (i % 2 == 0) ? 6'b000011 : 6'b000000;
            cyc(v);
            cyc(v);
            check("tcnt_step", {4'b0, io_out[5:4]}, 6'((i + 1) % 4));
        end
        cyc(6'b000001);
        cyc(6'b000001);
        rst_n = 1'b0;
        cyc(6'b000011);
        rst_n = 1'b1;
        check("midrun_reset", io_out, 6'b000010);
        check("midrun_oeb", io_oeb, 6'b000000);
        cyc(6'b000011);
        check("post_reset_sample", io_out, 6'b000010);

        for (int i = 0; i < 600; i++) begin
            logic [5:0] v;
            v = 6'($urandom);
            if ($urandom_range(0, 3) != 0) v[4] = 1'b0;
            rst_n = ($urandom_range(0, 40) != 0);
            cyc(v);
        end
        rst_n = 1'b1;
        cyc(6'b000000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/muller_c_proj_core.md
Name: muller_c_proj_core

Overview:
Synchronous Muller C-element block for the muller_c_proj user project, driven by a 6-bit io_in pad bus.
- Registers the pad inputs once.
- Maintains the C-element state: set when all selected inputs are 1, cleared when all are 0, held otherwise.
- Reports state, transition activity and a hold indicator on io_out.
- The formal wrapper (muller_c_proj_formal) instantiates it and drives io_in freely.

Parameters:
CNT_W, 2, width of the wrap-around transition counter driven on io_out[5:4].
IO_W, 6, width of the io_in/io_out/io_oeb buses; fixed at 6 for this project.

Ports:
clk  input  1  single system clock; all state updates on rising edge.
rst_n  input  1  reset; synchronous and active-low.
io_in  input  6  [0]=a, [1]=b, [2]=c, [3]=mode (0: 2-input a,b; 1: 3-input a,b,c), [4]=clr (synchronous force-to-0), [5]=inv (output polarity).
io_out  output  6  [0]=y (q XOR inv_q), [1]=~y, [2]=tpulse, [3]=hold, [5:4]=tcnt.
io_oeb  output  6  output enables, active-low; constant 6'b000000.

Behaviour:
- Input stage: in_q[5:0] <= io_in every rising edge. No other synchronisation. Every io_in effect is seen through in_q.
- Selected set:
  - mode_q=0: {a_q, b_q}.
  - mode_q=1: {a_q, b_q, c_q}.
  - In 2-input mode c_q is ignored entirely.
- all1 = every selected input is 1. all0 = every selected input is 0.
- State q update at each rising edge, with rst_n high, priority order:
  - clr_q=1 -> q <= 0.
  - else all1 -> q <= 1.
  - else all0 -> q <= 0.
  - else q holds.
- Latency: io_in change before edge k reaches in_q at edge k. q reflects it at edge k+1, i.e. 2 edges from pad to output.
- y = q XOR inv_q, combinational from registers. io_out[1] = ~y. inv only changes the reported polarity, never q.
- tpulse: registered. It is 1 for exactly the one cycle after any edge at which q changed value (including clr-forced changes), else 0.
- hold: combinational. It is 1 when clr_q=0 and neither all1 nor all0, i.e. the inputs disagree and q is being held.
- tcnt: CNT_W-bit counter, +1 on every q change, wraps 3->0.
- Simultaneous events:
  - clr_q with all1: q is forced to 0.
  - mode change while inputs disagree: the new selection is evaluated on the next edge.
- Reset: rst_n low at a rising edge sets in_q=0, q=0, tpulse=0, tcnt=0. Thus y=0, io_out=6'b000010, hold=0.
  - Reset has priority over everything, including mid-transition.
  - The first post-reset edge samples io_in normally.
- No X propagation allowed: all registers have reset values.

Decomposition:
- Shared package muller_c_proj_pkg holds:
  - io_in bit index constants: A=0, B=1, C=2, MODE=3, CLR=4, INV=5.
  - io_out index constants: Y=0, YN=1, TP=2, HOLD=3, CNT_LO=4.
  - OEB_ALL_OUT=6'b000000.
- One natural sub-module, muller_c_element: inputs a, b, c, mode, clr, clk, rst_n; output q.
- The top-level block adds the input register, polarity, tpulse, hold and tcnt logic.

Test Plan:
- Reset, then io_in=6'b110000 (inv=1, clr=1) held 3 cycles -> q=0, y=1, io_out[1:0]=2'b01, tpulse=0, tcnt=0, hold=0.
- Reset, then io_in=6'b000011 -> after 2 edges q=1, io_out[0]=1. tpulse=1 for one cycle, then 0. tcnt=1.
- From q=1, io_in=6'b000001 (disagree) for 4 cycles -> q stays 1, hold=1, tpulse=0. Then io_in=6'b000000 -> q=0 two edges later, tcnt=2.
- Mode 3-input: io_in=6'b001011 (c=0) -> q holds 0, hold=1. Then io_in=6'b001111 -> q=1 two edges later.
- clr priority: q=1 with io_in=6'b010011 -> q=0 two edges later, tpulse=1, even though a=b=1.
- Counter wrap and mid-run reset: 4 full toggles -> tcnt 1,2,3,0. Then rst_n low one edge mid-sequence -> tcnt=0, q=0, io_out=6'b000010, io_oeb=6'b000000 always.
